// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner
//   Conditions the raw country-road loop detector into the traffic
//   controller's x input: synchronise, debounce, count arrivals, and drain
//   the count while the country light is green.
//
// Ports:
//   clock      in   sole clock, rising edge
//   clear      in   synchronous active-high reset
//   loop_raw   in   asynchronous loop-detector level (1 = vehicle on loop)
//   cntry[1:0] in   country light state, 2'd2 = GREEN
//   x          out  registered, high while car_count != 0
//   car_count  out  cars queued (saturating)
//   car_event  out  one-cycle pulse per accepted arrival
//   overflow   out  sticky, arrival seen while count was at maximum
module car_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DRAIN_CYCLES    = 6,
    parameter int COUNT_WIDTH     = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   loop_raw,
    input  logic [1:0]             cntry,
    output logic                   x,
    output logic [COUNT_WIDTH-1:0] car_count,
    output logic                   car_event,
    output logic                   overflow
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]          DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]          TCNT_LAST = TW'(DRAIN_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [1:0]             GREEN     = 2'd2;

    logic                   s1_q, s1_d, s2_q, s2_d;
    logic                   lvl_q, lvl_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   x_q, x_d;
    logic                   event_q, event_d;
    logic                   ovf_q, ovf_d;
    logic                   arrival, tick;

    always_comb begin
        s1_d    = loop_raw;
        s2_d    = s1_q;
        lvl_d   = lvl_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = '0;
        tick    = 1'b0;
        count_d = count_q;
        ovf_d   = ovf_q;

        // dcnt counts consecutive samples disagreeing with the accepted level;
        // any agreeing sample restarts the persistence window.
        if (s2_q == lvl_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            lvl_d  = s2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
        arrival = lvl_d & ~lvl_q;

        // Drain timer only runs on GREEN with cars waiting, so a tick can
        // never hit an empty queue.
        if (cntry == GREEN && count_q != '0) begin
            if (tcnt_q == TCNT_LAST) tick = 1'b1;
            else                     tcnt_d = tcnt_q + 1'b1;
        end

        if (arrival && count_q == CNT_MAX) ovf_d = 1'b1;
        if (arrival && !tick) begin
            if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        end else if (tick && !arrival) begin
            count_d = count_q - 1'b1;
        end

        x_d     = (count_d != '0);
        event_d = arrival;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
            count_q <= '0;
            x_q     <= 1'b0;
            event_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            lvl_q   <= lvl_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
            count_q <= count_d;
            x_q     <= x_d;
            event_q <= event_d;
            ovf_q   <= ovf_d;
        end
    end

    assign x         = x_q;
    assign car_count = count_q;
    assign car_event = event_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_car_sensor_conditioner.sv
module tb_car_sensor_conditioner;
    localparam int DEB   = 4;
    localparam int DRAIN = 6;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          loop_raw = 1'b0;
    logic [1:0]    cntry = 2'd0;
    logic          x;
    logic [CW-1:0] car_count;
    logic          car_event;
    logic          overflow;

    car_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .DRAIN_CYCLES(DRAIN), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .clear(clear), .loop_raw(loop_raw), .cntry(cntry),
        .x(x), .car_count(car_count), .car_event(car_event), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit x;
        int cnt;
        bit ev;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: history of raw samples since the last clear.
    int rq[$];   // raw samples taken at each edge
    int dq[$];   // last DEB debounce inputs (raw delayed two edges)
    bit m_lvl;
    int m_cnt;
    bit m_ovf;
    int run;     // consecutive GREEN edges with a non-empty queue

    task automatic model(input bit r, input bit [1:0] c, input bit cl);
        exp_t e;
        bit   arr, tick, qual, flip;
        int   dv;
        arr = 1'b0;
        if (cl) begin
            rq.delete(); dq.delete();
            m_lvl = 1'b0; m_cnt = 0; m_ovf = 1'b0; run = 0;
        end else begin
            dv = (rq.size() >= 2) ? rq[rq.size()-2] : 0;
            rq.push_back(int'(r));
            if (rq.size() > 4) void'(rq.pop_front());
            dq.push_back(dv);
            if (dq.size() > DEB) void'(dq.pop_front());
            // Level accepted once the last DEB samples all disagree with it.
            flip = (dq.size() == DEB);
            foreach (dq[i]) if (dq[i] == int'(m_lvl)) flip = 1'b0;
            if (flip) begin
                m_lvl = ~m_lvl;
                arr   = m_lvl;
            end
            qual = (c == 2'd2) && (m_cnt != 0);
            run  = qual ? run + 1 : 0;
            tick = qual && (run % DRAIN == 0);
            if (arr && m_cnt == MAXC) m_ovf = 1'b1;
            if (arr && !tick && m_cnt < MAXC) m_cnt++;
            else if (tick && !arr) m_cnt--;
        end
        e.x = (m_cnt != 0); e.cnt = m_cnt; e.ev = arr; e.ovf = m_ovf;
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs away from the edge, predict that edge.
    task automatic cyc(input bit r, input bit [1:0] c, input bit cl);
        @(negedge clock);
        loop_raw = r; cntry = c; clear = cl;
        model(r, c, cl);
    endtask

    task automatic hold(input int n, input bit r, input bit [1:0] c);
        for (int i = 0; i < n; i++) cyc(r, c, 1'b0);
    endtask

    // Monitor: every edge the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (x === e.x && car_count === CW'(e.cnt) && car_event === e.ev
                    && overflow === e.ovf) begin
                    passes++;
                end else begin
                    $display("FAIL outputs @%0t: got x=%b cnt=%0d ev=%b ovf=%b, want x=%b cnt=%0d ev=%b ovf=%b",
                             $time, x, car_count, car_event, overflow, e.x, e.cnt, e.ev, e.ovf);
                end
            end
        end
    end

    initial begin
        int rl, cl_len, cn_len, wait_cyc;
        bit r;
        bit [1:0] c;

        // Reset with vehicle on the loop; counted again after release.
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 1'b1);
        hold(10, 1'b1, 2'd0);
        hold(8, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 1'b1);

        // Glitch rejection.
        hold(3, 1'b1, 2'd0);
        hold(10, 1'b0, 2'd0);

        // Three clean cars on RED.
        for (int k = 0; k < 3; k++) begin
            hold(8, 1'b1, 2'd0);
            hold(8, 1'b0, 2'd0);
        end

        // Interrupted green: partial interval lost.
        hold(4, 1'b0, 2'd2);
        hold(3, 1'b0, 2'd0);
        hold(2, 1'b0, 2'd3);
        // Full drain of the three cars.
        hold(22, 1'b0, 2'd2);
        hold(2, 1'b0, 2'd0);

        // Three cars again, then arrival coinciding with the second tick.
        for (int k = 0; k < 3; k++) begin
            hold(8, 1'b1, 2'd0);
            hold(8, 1'b0, 2'd0);
        end
        hold(6, 1'b0, 2'd2);
        hold(6, 1'b1, 2'd2);
        hold(8, 1'b0, 2'd0);

        // Saturation: 16 more arrivals, then drain; overflow stays set.
        for (int k = 0; k < 16; k++) begin
            hold(5, 1'b1, 2'd0);
            hold(5, 1'b0, 2'd0);
        end
        hold(40, 1'b0, 2'd2);
        cyc(1'b0, 2'd0, 1'b1);
        hold(3, 1'b0, 2'd0);

        // Random traffic with held levels, all light codes and rare clears.
        r = 1'b0; c = 2'd0; rl = 0; cn_len = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rl == 0) begin r = ~r; rl = $urandom_range(1, 12); end
            if (cn_len == 0) begin c = 2'($urandom_range(0, 3)); cn_len = $urandom_range(1, 30); end
            rl--; cn_len--;
            cl_len = $urandom_range(0, 499);
            cyc(r, c, cl_len == 0);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clock);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
